// File: rtl/qam_rx_pkg.sv
// Shared receive-path definitions: baud-rate codes, decimation helpers and
// the default sample width.
package qam_rx_pkg;

  localparam int SAMP_W_DEF = 32;

  localparam logic [1:0] BAUD_9600  = 2'b00;
  localparam logic [1:0] BAUD_19200 = 2'b01;
  localparam logic [1:0] BAUD_38400 = 2'b10;
  localparam logic [1:0] BAUD_76800 = 2'b11;

  typedef enum logic {
    MODE_PICK = 1'b0,
    MODE_AVG  = 1'b1
  } samp_mode_e;

  // Filter samples per symbol for a baud-rate code.
  function automatic logic [3:0] decim_factor(input logic [1:0] baud_rate);
    case (baud_rate)
      BAUD_9600:  return 4'd8;
      BAUD_19200: return 4'd4;
      BAUD_38400: return 4'd2;
      default:    return 4'd1;
    endcase
  endfunction

  // log2 of the decimation factor, used as the averaging shift.
  function automatic logic [1:0] decim_log2(input logic [1:0] baud_rate);
    case (baud_rate)
      BAUD_9600:  return 2'd3;
      BAUD_19200: return 2'd2;
      BAUD_38400: return 2'd1;
      default:    return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sym_fifo2.sv
// Two-entry synchronous FIFO with the head held in a register, so the output
// never falls through combinationally from the write side.
module sym_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk_filter_sample,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   cnt_q;
  logic         pop_ok;
  logic         push_ok;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign dout    = head_q;
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO only lands when the head leaves the same cycle.
  assign push_ok = push && (!full || pop_ok);

  // Occupancy and storage update; head always holds the oldest entry.
  always_ff @(posedge clk_filter_sample) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push_ok) begin
            head_q <= din;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push_ok && pop_ok) begin
            head_q <= din;
          end else if (push_ok) begin
            tail_q <= din;
            cnt_q  <= 2'd2;
          end else if (pop_ok) begin
            cnt_q <= 2'd0;
          end
        end
        default: begin
          if (pop_ok) begin
            head_q <= tail_q;
            if (push_ok) tail_q <= din;
            else         cnt_q  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/filter_out_downsamp.sv
// Decimates the matched-filter I/Q stream to one symbol per baud period,
// either picking one sample at a programmable phase or averaging the period,
// and queues symbols for the demapper in a 2-entry FIFO.
module filter_out_downsamp
  import qam_rx_pkg::*;
#(
  parameter int SAMP_W = SAMP_W_DEF
) (
  input  logic                     clk_filter_sample,
  input  logic                     rst,
  input  logic [1:0]               baud_rate,
  input  logic [2:0]               samp_phase,
  input  logic                     avg_mode,
  input  logic signed [SAMP_W-1:0] samp_i,
  input  logic signed [SAMP_W-1:0] samp_q,
  input  logic                     samp_valid,
  output logic signed [SAMP_W-1:0] symb_i,
  output logic signed [SAMP_W-1:0] symb_q,
  output logic                     symb_valid,
  input  logic                     symb_ready,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int ACC_W = SAMP_W + 3;

  logic [1:0]              baud_q;
  samp_mode_e              mode_q;
  logic                    reconfig;
  logic [2:0]              cnt;
  logic [2:0]              cnt_last;
  logic [2:0]              phase_sel;
  logic [1:0]              shift;
  logic                    last_samp;

  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic signed [ACC_W-1:0] ext_i, ext_q;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic signed [ACC_W-1:0] shr_i, shr_q;

  logic                    push;
  logic [2*SAMP_W-1:0]     push_data;
  logic [2*SAMP_W-1:0]     head_data;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign reconfig  = (baud_rate != baud_q) || (avg_mode != logic'(mode_q));
  assign cnt_last  = 3'(decim_factor(baud_q) - 4'd1);
  assign phase_sel = samp_phase & cnt_last;
  assign shift     = decim_log2(baud_q);
  assign last_samp = (cnt == cnt_last);

  assign ext_i = {{3{samp_i[SAMP_W-1]}}, samp_i};
  assign ext_q = {{3{samp_q[SAMP_W-1]}}, samp_q};
  assign sum_i = ((cnt == 3'd0) ? '0 : acc_i) + ext_i;
  assign sum_q = ((cnt == 3'd0) ? '0 : acc_q) + ext_q;
  assign shr_i = sum_i >>> shift;
  assign shr_q = sum_q >>> shift;

  // A sample arriving alongside a config change belongs to no symbol.
  assign push = samp_valid && !reconfig &&
                ((mode_q == MODE_AVG) ? last_samp : (cnt == phase_sel));
  assign push_data = (mode_q == MODE_AVG) ? {shr_i[SAMP_W-1:0], shr_q[SAMP_W-1:0]}
                                          : {samp_i, samp_q};

  assign pop        = symb_valid && symb_ready;
  assign symb_valid = !fifo_empty;
  assign symb_i     = head_data[2*SAMP_W-1:SAMP_W];
  assign symb_q     = head_data[SAMP_W-1:0];

  // Phase counter, accumulators and config tracking; a config change drops the partial symbol.
  always_ff @(posedge clk_filter_sample) begin
    if (rst) begin
      baud_q <= baud_rate;
      mode_q <= samp_mode_e'(avg_mode);
      cnt    <= 3'd0;
      acc_i  <= '0;
      acc_q  <= '0;
    end else begin
      baud_q <= baud_rate;
      mode_q <= samp_mode_e'(avg_mode);
      if (reconfig) begin
        cnt   <= 3'd0;
        acc_i <= '0;
        acc_q <= '0;
      end else if (samp_valid) begin
        cnt   <= last_samp ? 3'd0 : cnt + 3'd1;
        acc_i <= last_samp ? '0 : sum_i;
        acc_q <= last_samp ? '0 : sum_q;
      end
    end
  end

  // Sticky drop flag; a clear wins over a drop in the same cycle.
  always_ff @(posedge clk_filter_sample) begin
    if (rst)                             overflow <= 1'b0;
    else if (ovf_clr)                    overflow <= 1'b0;
    else if (push && fifo_full && !pop)  overflow <= 1'b1;
  end

  sym_fifo2 #(
    .W(2*SAMP_W)
  ) u_fifo (
    .clk_filter_sample (clk_filter_sample),
    .rst               (rst),
    .push              (push),
    .din               (push_data),
    .pop               (pop),
    .dout              (head_data),
    .full              (fifo_full),
    .empty             (fifo_empty)
  );

endmodule

// File: tb/tb_filter_out_downsamp.sv
// Bench for filter_out_downsamp: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a sample-list model.
module tb_filter_out_downsamp;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         baud_rate;
  logic [2:0]         samp_phase;
  logic               avg_mode;
  logic signed [31:0] samp_i, samp_q;
  logic               samp_valid;
  logic signed [31:0] symb_i, symb_q;
  logic               symb_valid;
  logic               symb_ready;
  logic               overflow;
  logic               ovf_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_out_downsamp #(.SAMP_W(32)) dut (
    .clk_filter_sample (clk),
    .rst               (rst),
    .baud_rate         (baud_rate),
    .samp_phase        (samp_phase),
    .avg_mode          (avg_mode),
    .samp_i            (samp_i),
    .samp_q            (samp_q),
    .samp_valid        (samp_valid),
    .symb_i            (symb_i),
    .symb_q            (symb_q),
    .symb_valid        (symb_valid),
    .symb_ready        (symb_ready),
    .overflow          (overflow),
    .ovf_clr           (ovf_clr)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: current symbol kept as a list of samples, FIFO as a queue.
  longint             cur_i[$], cur_q[$];
  logic signed [31:0] fq_i[$], fq_q[$];
  logic [1:0]         m_baud;
  logic               m_avg;
  logic               m_ovf;
  bit                 m_init = 0;

  always @(posedge clk) begin
    int d, lg, idx;
    bit pop, push, drop;
    logic signed [31:0] pi, pq;
    longint si, sq;
    if (rst) begin
      cur_i.delete(); cur_q.delete(); fq_i.delete(); fq_q.delete();
      m_baud = baud_rate; m_avg = avg_mode; m_ovf = 1'b0; m_init = 1;
    end else if (m_init) begin
      pop  = (fq_i.size() > 0) && symb_ready;
      push = 0; pi = '0; pq = '0;
      if (baud_rate != m_baud || avg_mode != m_avg) begin
        cur_i.delete(); cur_q.delete();
      end else if (samp_valid) begin
        lg = 3 - int'(baud_rate);
        d  = 1 << lg;
        cur_i.push_back(longint'(samp_i));
        cur_q.push_back(longint'(samp_q));
        idx = cur_i.size() - 1;
        if (!avg_mode) begin
          if (idx == (int'(samp_phase) & (d - 1))) begin
            push = 1; pi = 32'(cur_i[idx]); pq = 32'(cur_q[idx]);
          end
        end else if (cur_i.size() == d) begin
          si = 0; sq = 0;
          foreach (cur_i[k]) begin si += cur_i[k]; sq += cur_q[k]; end
          push = 1; pi = 32'(si >>> lg); pq = 32'(sq >>> lg);
        end
        if (cur_i.size() == d) begin cur_i.delete(); cur_q.delete(); end
      end
      m_baud = baud_rate; m_avg = avg_mode;
      drop = push && (fq_i.size() == 2) && !pop;
      if (pop) begin void'(fq_i.pop_front()); void'(fq_q.pop_front()); end
      if (push && !drop) begin fq_i.push_back(pi); fq_q.push_back(pq); end
      if (ovf_clr) m_ovf = 1'b0;
      else if (drop) m_ovf = 1'b1;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("symb_valid", longint'(symb_valid), longint'(fq_i.size() > 0));
      if (fq_i.size() > 0 && symb_valid) begin
        chk("symb_i", longint'(symb_i), longint'(fq_i[0]));
        chk("symb_q", longint'(symb_q), longint'(fq_q[0]));
      end
      chk("overflow", longint'(overflow), longint'(m_ovf));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic smp(input int vi, input int vq);
    samp_valid = 1'b1; samp_i = vi; samp_q = vq;
    tick();
    samp_valid = 1'b0;
  endtask

  task automatic idle();
    samp_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; baud_rate = 2'b00; avg_mode = 1'b0; samp_phase = 3'd3;
    samp_i = '0; samp_q = '0; samp_valid = 1'b0; symb_ready = 1'b1; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_valid", longint'(symb_valid), 0);
    chk("rst_symb_i", longint'(symb_i), 0);
    chk("rst_ovf", longint'(overflow), 0);
    rst = 1'b0;

    // Pick, D=8, phase 3 on a ramp.
    for (int k = 0; k < 20; k++) begin
      smp(k, -k);
      if (k == 3 || k == 11 || k == 19) begin
        chk("pick_valid", longint'(symb_valid), 1);
        chk("pick_i", longint'(symb_i), k);
        chk("pick_q", longint'(symb_q), -k);
      end
      if (k == 4) chk("pick_gap", longint'(symb_valid), 0);
    end

    // Average, D=4, including floor on negatives.
    baud_rate = 2'b01; avg_mode = 1'b1; idle();
    smp(4, 8); smp(8, 16); smp(-4, -8); smp(12, 24);
    chk("avg_i", longint'(symb_i), 5);
    chk("avg_q", longint'(symb_q), 10);
    smp(-1, -2); smp(-1, -2); smp(-1, -2); smp(-2, -4);
    chk("avg_floor_i", longint'(symb_i), -2);
    chk("avg_floor_q", longint'(symb_q), -3);

    // D=1 overflow with consumer stalled, then clear.
    baud_rate = 2'b11; avg_mode = 1'b0; idle();
    symb_ready = 1'b0;
    smp(10, 1); smp(20, 2); smp(30, 3); smp(40, 4);
    chk("ovf_set", longint'(overflow), 1);
    chk("ovf_head", longint'(symb_i), 10);
    ovf_clr = 1'b1; idle(); ovf_clr = 1'b0;
    chk("ovf_clr", longint'(overflow), 0);
    chk("ovf_head_hold", longint'(symb_i), 10);
    symb_ready = 1'b1; idle();
    chk("ovf_second", longint'(symb_i), 20);
    idle();
    chk("ovf_drain", longint'(symb_valid), 0);

    // Full FIFO with simultaneous push/pop: nothing dropped.
    symb_ready = 1'b0;
    smp(50, 5); smp(60, 6);
    symb_ready = 1'b1;
    smp(70, 7);
    chk("fp_head1", longint'(symb_i), 60);
    smp(80, 8);
    chk("fp_head2", longint'(symb_i), 70);
    chk("fp_ovf", longint'(overflow), 0);
    idle();
    chk("fp_head3", longint'(symb_i), 80);
    idle();
    chk("fp_empty", longint'(symb_valid), 0);

    // Baud change mid-symbol discards partial, restarts the count.
    baud_rate = 2'b00; avg_mode = 1'b1; idle();
    for (int k = 0; k < 5; k++) smp(100, 100);
    baud_rate = 2'b10;
    smp(999, 999);
    smp(6, -6);
    chk("recfg_none", longint'(symb_valid), 0);
    smp(9, -9);
    chk("recfg_i", longint'(symb_i), 7);
    chk("recfg_q", longint'(symb_q), -8);

    // Reset mid-symbol with one queued symbol.
    baud_rate = 2'b01; idle();
    symb_ready = 1'b0;
    smp(4, 4); smp(4, 4); smp(4, 4); smp(4, 4);
    smp(7, 7); smp(7, 7);
    rst = 1'b1; idle();
    chk("rst_mid_valid", longint'(symb_valid), 0);
    chk("rst_mid_ovf", longint'(overflow), 0);
    rst = 1'b0; symb_ready = 1'b1;
    smp(1, 1); smp(2, 2); smp(3, 3); smp(6, 6);
    chk("rst_fresh_i", longint'(symb_i), 3);
    idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) baud_rate = 2'($urandom);
      if ($urandom_range(0, 59) == 0) avg_mode = 1'($urandom);
      if ($urandom_range(0, 9) == 0) samp_phase = 3'($urandom);
      samp_valid = ($urandom_range(0, 3) != 0);
      samp_i     = $urandom;
      samp_q     = $urandom;
      symb_ready = ($urandom_range(0, 9) < 7);
      ovf_clr    = ($urandom_range(0, 19) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; samp_valid = 1'b0; ovf_clr = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
